// File: rtl/lv8_ctrl_pkg.sv
// Shared LEGv8 control encodings: opcode IDs, sequencer states and datapath select codes.
// Also used by the single-cycle decoder.
package lv8_ctrl_pkg;

    localparam logic [3:0] OpAddi = 4'd0;
    localparam logic [3:0] OpAdds = 4'd1;
    localparam logic [3:0] OpBlt  = 4'd2;
    localparam logic [3:0] OpB    = 4'd3;
    localparam logic [3:0] OpBl   = 4'd4;
    localparam logic [3:0] OpBr   = 4'd5;
    localparam logic [3:0] OpCbz  = 4'd6;
    localparam logic [3:0] OpLdur = 4'd7;
    localparam logic [3:0] OpStur = 4'd8;
    localparam logic [3:0] OpSubs = 4'd9;

    typedef logic [2:0] state_t;

    localparam state_t StRst    = 3'd0;
    localparam state_t StFetch  = 3'd1;
    localparam state_t StDecode = 3'd2;
    localparam state_t StExec   = 3'd3;
    localparam state_t StMem    = 3'd4;
    localparam state_t StWb     = 3'd5;
    localparam state_t StFault  = 3'd6;

    localparam logic [2:0] AluPassB = 3'b000;
    localparam logic [2:0] AluAdd   = 3'b010;
    localparam logic [2:0] AluSub   = 3'b011;

    localparam logic [1:0] WbAlu = 2'b00;
    localparam logic [1:0] WbMdr = 2'b01;
    localparam logic [1:0] WbPc4 = 2'b10;

    localparam logic [1:0] PcPlus4 = 2'b00;
    localparam logic [1:0] PcImm   = 2'b01;
    localparam logic [1:0] PcReg   = 2'b10;

    // Returns {alu_op, alu_src} for the execute step of an opcode.
    function automatic logic [3:0] alu_ctrl(input logic [3:0] op);
        logic [3:0] r;
        r = {AluPassB, 1'b0};
        case (op)
            OpAddi:         r = {AluAdd, 1'b1};
            OpAdds:         r = {AluAdd, 1'b0};
            OpSubs:         r = {AluSub, 1'b0};
            OpLdur, OpStur: r = {AluAdd, 1'b1};
            default:        r = {AluPassB, 1'b0};
        endcase
        return r;
    endfunction

    function automatic logic is_branch(input logic [3:0] op);
        return (op == OpBlt) || (op == OpB) || (op == OpBl) || (op == OpBr) || (op == OpCbz);
    endfunction

    function automatic logic is_mem(input logic [3:0] op);
        return (op == OpLdur) || (op == OpStur);
    endfunction

    function automatic logic is_alu(input logic [3:0] op);
        return (op == OpAddi) || (op == OpAdds) || (op == OpSubs);
    endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Memory-wait watchdog: counts cycles a request waits for ready and flags the limit.
// The count is held at zero whenever no request is waiting, so every entry starts fresh.
module mem_watchdog #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic active_i,
    input  logic ready_i,
    output logic timeout_o
);

    localparam int unsigned CW = $clog2(MEM_TIMEOUT);
    localparam logic [CW-1:0] Limit = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        if (active_i && !ready_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Fires on the MEM_TIMEOUT-th waiting cycle; a ready in that cycle suppresses it.
    assign timeout_o = active_i && !ready_i && (cnt_q == Limit);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle LEGv8 control sequencer: FETCH/DECODE/EXEC/MEM/WB with ready handshakes,
// memory-wait watchdog, sticky fault and retired-instruction counter.
module mc_sequencer
    import lv8_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       opid,
    input  logic [3:0]       flags,
    input  logic             alu_zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_we,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             mdr_we,
    output logic             alu_src,
    output logic [2:0]       alu_op,
    output logic             flag_we,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);

    state_t           state_q, state_d;
    logic [3:0]       opid_q, opid_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             wd_active, wd_ready, wd_timeout;

    assign wd_active = (state_q == StFetch) || (state_q == StMem);
    assign wd_ready  = (state_q == StFetch) ? imem_ready : dmem_ready;

    mem_watchdog #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_mem_watchdog (
        .clk      (clk),
        .reset_n  (reset_n),
        .active_i (wd_active),
        .ready_i  (wd_ready),
        .timeout_o(wd_timeout)
    );

    always_comb begin
        state_d = state_q;
        opid_d  = opid_q;
        case (state_q)
            StRst:   state_d = StFetch;
            StFetch: begin
                if (imem_ready) begin
                    state_d = StDecode;
                end else if (wd_timeout) begin
                    state_d = StFault;
                end
            end
            StDecode: begin
                opid_d  = opid;
                state_d = (opid > OpSubs) ? StFault : StExec;
            end
            StExec: begin
                if (is_branch(opid_q)) begin
                    state_d = StFetch;
                end else if (is_mem(opid_q)) begin
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                if (dmem_ready) begin
                    state_d = (opid_q == OpStur) ? StFetch : StWb;
                end else if (wd_timeout) begin
                    state_d = StFault;
                end
            end
            StWb:    state_d = StFetch;
            StFault: state_d = StFault;
            default: state_d = StFault;
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        mdr_we   = 1'b0;
        alu_src  = 1'b0;
        alu_op   = AluPassB;
        flag_we  = 1'b0;
        reg_we   = 1'b0;
        wb_sel   = WbAlu;
        pc_we    = 1'b0;
        pc_sel   = PcPlus4;
        fault    = 1'b0;
        case (state_q)
            StFetch: begin
                imem_req = 1'b1;
                ir_we    = imem_ready;
            end
            StExec: begin
                {alu_op, alu_src} = alu_ctrl(opid_q);
                flag_we = (opid_q == OpAdds) || (opid_q == OpSubs);
                case (opid_q)
                    OpB: begin
                        pc_we  = 1'b1;
                        pc_sel = PcImm;
                    end
                    OpBl: begin
                        pc_we  = 1'b1;
                        pc_sel = PcImm;
                        reg_we = 1'b1;
                        wb_sel = WbPc4;
                    end
                    OpBr: begin
                        pc_we  = 1'b1;
                        pc_sel = PcReg;
                    end
                    OpBlt: begin
                        pc_we  = 1'b1;
                        pc_sel = (flags[3] ^ flags[0]) ? PcImm : PcPlus4;
                    end
                    OpCbz: begin
                        pc_we  = 1'b1;
                        pc_sel = alu_zero ? PcImm : PcPlus4;
                    end
                    default: ;
                endcase
            end
            StMem: begin
                dmem_req = 1'b1;
                alu_op   = AluAdd;
                alu_src  = 1'b1;
                dmem_we  = (opid_q == OpStur);
                if (dmem_ready) begin
                    if (opid_q == OpStur) begin
                        pc_we = 1'b1;
                    end else begin
                        mdr_we = 1'b1;
                    end
                end
            end
            StWb: begin
                reg_we = 1'b1;
                pc_we  = 1'b1;
                wb_sel = (opid_q == OpLdur) ? WbMdr : WbAlu;
                if (is_alu(opid_q)) begin
                    {alu_op, alu_src} = alu_ctrl(opid_q);
                end
            end
            StFault: fault = 1'b1;
            default: ;
        endcase
    end

    assign retired_d = retired_q + CNT_W'(pc_we);
    assign retired   = retired_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StRst;
            opid_q    <= 4'd0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            opid_q    <= opid_d;
            retired_q <= retired_d;
        end
    end

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer: directed table, multi-cycle corner cases and
// randomized instructions against an instruction-level reference model.
module tb_mc_sequencer;

    localparam int unsigned MemTimeout = 4;
    localparam int unsigned CntW       = 4;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [3:0]      opid;
    logic [3:0]      flags;
    logic            alu_zero;
    logic            imem_ready;
    logic            dmem_ready;
    logic            imem_req, ir_we, dmem_req, dmem_we, mdr_we, alu_src;
    logic [2:0]      alu_op;
    logic            flag_we, reg_we;
    logic [1:0]      wb_sel;
    logic            pc_we;
    logic [1:0]      pc_sel;
    logic            fault;
    logic [CntW-1:0] retired;

    always #5 clk = ~clk;

    mc_sequencer #(
        .MEM_TIMEOUT(MemTimeout),
        .CNT_W      (CntW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .opid      (opid),
        .flags     (flags),
        .alu_zero  (alu_zero),
        .imem_ready(imem_ready),
        .dmem_ready(dmem_ready),
        .imem_req  (imem_req),
        .ir_we     (ir_we),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .mdr_we    (mdr_we),
        .alu_src   (alu_src),
        .alu_op    (alu_op),
        .flag_we   (flag_we),
        .reg_we    (reg_we),
        .wb_sel    (wb_sel),
        .pc_we     (pc_we),
        .pc_sel    (pc_sel),
        .fault     (fault),
        .retired   (retired)
    );

    typedef struct packed {
        logic       imem_req, ir_we, dmem_req, dmem_we, mdr_we, alu_src;
        logic [2:0] alu_op;
        logic       flag_we, reg_we;
        logic [1:0] wb_sel;
        logic       pc_we;
        logic [1:0] pc_sel;
        logic       fault;
    } out_t;

    typedef struct {
        logic ir;
        logic dr;
        out_t o;
    } cyc_t;

    typedef struct {
        logic [3:0] op;
        logic [3:0] fl;
        logic       z;
        int         wi;
        int         wd;
        int         lat;
        logic [2:0] alu_op;
        logic       alu_src;
        logic       flag_we;
        logic       reg_we;
        logic [1:0] wb_sel;
        logic       pc_we;
        logic [1:0] pc_sel;
    } vec_t;

    cyc_t            exp_q[$];
    vec_t            tbl[15];
    int              errors = 0;
    int              checks = 0;
    logic [CntW-1:0] exp_ret;

    function automatic out_t dut_out();
        out_t o;
        o = {imem_req, ir_we, dmem_req, dmem_we, mdr_we, alu_src, alu_op, flag_we, reg_we,
             wb_sel, pc_we, pc_sel, fault};
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void push(input logic ir, input logic dr, input out_t o);
        cyc_t c;
        c.ir = ir;
        c.dr = dr;
        c.o  = o;
        exp_q.push_back(c);
    endfunction

    // Expands one instruction into its expected cycle-by-cycle outputs and ready inputs.
    function automatic void model_instr(input logic [3:0] op, input logic [3:0] fl, input logic z,
                                        input int wi, input int wd);
        out_t o;
        bit   mem_op, br_op, alu_op_k;
        mem_op   = (op == 4'd7) || (op == 4'd8);
        br_op    = (op >= 4'd2) && (op <= 4'd6);
        alu_op_k = (op == 4'd0) || (op == 4'd1) || (op == 4'd9);
        for (int k = 0; k <= wi; k++) begin
            o = '0;
            o.imem_req = 1'b1;
            o.ir_we    = (k == wi);
            push(k == wi, 1'b0, o);
        end
        push(1'b0, 1'b0, '0);
        o = '0;
        case (op)
            4'd0:       begin o.alu_op = 3'b010; o.alu_src = 1'b1; end
            4'd1:       begin o.alu_op = 3'b010; o.flag_we = 1'b1; end
            4'd9:       begin o.alu_op = 3'b011; o.flag_we = 1'b1; end
            4'd7, 4'd8: begin o.alu_op = 3'b010; o.alu_src = 1'b1; end
            4'd2:       begin o.pc_we = 1'b1; o.pc_sel = (fl[3] ^ fl[0]) ? 2'b01 : 2'b00; end
            4'd3:       begin o.pc_we = 1'b1; o.pc_sel = 2'b01; end
            4'd4: begin
                o.pc_we = 1'b1; o.pc_sel = 2'b01; o.reg_we = 1'b1; o.wb_sel = 2'b10;
            end
            4'd5:       begin o.pc_we = 1'b1; o.pc_sel = 2'b10; end
            4'd6:       begin o.pc_we = 1'b1; o.pc_sel = z ? 2'b01 : 2'b00; end
            default: ;
        endcase
        push(1'b0, 1'b0, o);
        if (mem_op) begin
            for (int k = 0; k <= wd; k++) begin
                o = '0;
                o.dmem_req = 1'b1;
                o.alu_op   = 3'b010;
                o.alu_src  = 1'b1;
                o.dmem_we  = (op == 4'd8);
                if (k == wd) begin
                    if (op == 4'd8) o.pc_we = 1'b1;
                    else            o.mdr_we = 1'b1;
                end
                push(1'b0, k == wd, o);
            end
        end
        if (!br_op && op != 4'd8) begin
            o = '0;
            o.reg_we = 1'b1;
            o.pc_we  = 1'b1;
            o.wb_sel = (op == 4'd7) ? 2'b01 : 2'b00;
            if (alu_op_k) begin
                o.alu_op  = (op == 4'd9) ? 3'b011 : 3'b010;
                o.alu_src = (op == 4'd0);
            end
            push(1'b0, 1'b0, o);
        end
    endfunction

    // Plays the expected queue: drives readies after each edge, samples 2 time units later.
    task automatic run_queue(input string tag, input int exec_idx, output int lat,
                             output out_t exec_o);
        cyc_t c;
        out_t seen;
        int   n;
        n      = 0;
        lat    = 0;
        exec_o = '0;
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front();
            imem_ready = c.ir;
            dmem_ready = c.dr;
            #2;
            seen = dut_out();
            if (n == exec_idx) exec_o = seen;
            if (seen.pc_we && lat == 0) lat = n + 1;
            chk($sformatf("%s cyc%0d outs", tag, n), 32'(seen), 32'(c.o));
            chk($sformatf("%s cyc%0d retired", tag, n), 32'(retired), 32'(exp_ret));
            @(posedge clk);
            #1;
            if (c.o.pc_we) exp_ret = exp_ret + 1'b1;
            n++;
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
    endtask

    task automatic run_instr(input logic [3:0] op, input logic [3:0] fl, input logic z,
                             input int wi, input int wd, output int lat, output out_t exec_o);
        exp_q.delete();
        model_instr(op, fl, z, wi, wd);
        opid     = op;
        flags    = fl;
        alu_zero = z;
        run_queue($sformatf("op%0d", op), wi + 2, lat, exec_o);
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        opid       = 4'd0;
        flags      = 4'd0;
        alu_zero   = 1'b0;
        @(posedge clk);
        #1;
        chk("reset outs", 32'(dut_out()), 32'd0);
        chk("reset retired", 32'(retired), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst state outs", 32'(dut_out()), 32'd0);
        @(posedge clk);
        #1;
        exp_ret = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL global time limit reached");
        $fatal(1);
    end

    initial begin
        int   lat;
        out_t eo, ee, o;

        //         op     fl     z     wi wd lat alu     src   fw    rw    wb     pcwe  pcsel
        tbl[0]  = '{4'd1, 4'h0, 1'b0, 0, 0, 4, 3'b010, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00};
        tbl[1]  = '{4'd0, 4'h0, 1'b0, 0, 0, 4, 3'b010, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00};
        tbl[2]  = '{4'd9, 4'h0, 1'b0, 0, 0, 4, 3'b011, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00};
        tbl[3]  = '{4'd7, 4'h0, 1'b0, 0, 3, 8, 3'b010, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00};
        tbl[4]  = '{4'd7, 4'h0, 1'b0, 0, 0, 5, 3'b010, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00};
        tbl[5]  = '{4'd8, 4'h0, 1'b0, 0, 0, 4, 3'b010, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00};
        tbl[6]  = '{4'd8, 4'h0, 1'b0, 1, 2, 7, 3'b010, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00};
        tbl[7]  = '{4'd2, 4'h8, 1'b0, 0, 0, 3, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01};
        tbl[8]  = '{4'd2, 4'h9, 1'b0, 0, 0, 3, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00};
        tbl[9]  = '{4'd3, 4'h0, 1'b0, 0, 0, 3, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01};
        tbl[10] = '{4'd4, 4'h0, 1'b0, 0, 0, 3, 3'b000, 1'b0, 1'b0, 1'b1, 2'b10, 1'b1, 2'b01};
        tbl[11] = '{4'd5, 4'h0, 1'b0, 0, 0, 3, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b10};
        tbl[12] = '{4'd6, 4'h0, 1'b1, 0, 0, 3, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b01};
        tbl[13] = '{4'd6, 4'h0, 1'b0, 0, 0, 3, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00};
        tbl[14] = '{4'd1, 4'h0, 1'b0, 3, 0, 7, 3'b010, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00};

        do_reset();
        for (int i = 0; i < 15; i++) begin
            run_instr(tbl[i].op, tbl[i].fl, tbl[i].z, tbl[i].wi, tbl[i].wd, lat, eo);
            if (i == 0) chk("adds retired after 5 clocks", 32'(retired), 32'd1);
            ee = '0;
            ee.alu_op  = tbl[i].alu_op;
            ee.alu_src = tbl[i].alu_src;
            ee.flag_we = tbl[i].flag_we;
            ee.reg_we  = tbl[i].reg_we;
            ee.wb_sel  = tbl[i].wb_sel;
            ee.pc_we   = tbl[i].pc_we;
            ee.pc_sel  = tbl[i].pc_sel;
            chk($sformatf("tbl%0d latency", i), 32'(lat), 32'(tbl[i].lat));
            chk($sformatf("tbl%0d exec outs", i), 32'(eo), 32'(ee));
        end

        // Fetch watchdog: ready never arrives, fault after 4 waiting cycles and stays.
        do_reset();
        exp_q.delete();
        for (int k = 0; k < 4; k++) begin
            o = '0; o.imem_req = 1'b1; push(1'b0, 1'b0, o);
        end
        for (int k = 0; k < 5; k++) begin
            o = '0; o.fault = 1'b1; push(1'b1, 1'b1, o);
        end
        run_queue("wd fetch", -1, lat, eo);

        // Illegal opid faults straight after DECODE.
        do_reset();
        opid = 4'hF;
        exp_q.delete();
        o = '0; o.imem_req = 1'b1; o.ir_we = 1'b1; push(1'b1, 1'b0, o);
        push(1'b0, 1'b0, '0);
        for (int k = 0; k < 3; k++) begin
            o = '0; o.fault = 1'b1; push(1'b1, 1'b0, o);
        end
        run_queue("illegal opid", -1, lat, eo);

        // Data-memory watchdog on a STUR that never completes.
        do_reset();
        opid = 4'd8;
        exp_q.delete();
        o = '0; o.imem_req = 1'b1; o.ir_we = 1'b1; push(1'b1, 1'b0, o);
        push(1'b0, 1'b0, '0);
        o = '0; o.alu_op = 3'b010; o.alu_src = 1'b1; push(1'b0, 1'b0, o);
        for (int k = 0; k < 4; k++) begin
            o = '0; o.dmem_req = 1'b1; o.dmem_we = 1'b1; o.alu_op = 3'b010; o.alu_src = 1'b1;
            push(1'b0, 1'b0, o);
        end
        for (int k = 0; k < 3; k++) begin
            o = '0; o.fault = 1'b1; push(1'b0, 1'b1, o);
        end
        run_queue("wd mem", -1, lat, eo);

        // Reset asserted while a STUR waits in MEM.
        do_reset();
        run_instr(4'd3, 4'h0, 1'b0, 0, 0, lat, eo);
        run_instr(4'd3, 4'h0, 1'b0, 0, 0, lat, eo);
        chk("pre-reset retired", 32'(retired), 32'd2);
        opid = 4'd8;
        exp_q.delete();
        o = '0; o.imem_req = 1'b1; o.ir_we = 1'b1; push(1'b1, 1'b0, o);
        push(1'b0, 1'b0, '0);
        o = '0; o.alu_op = 3'b010; o.alu_src = 1'b1; push(1'b0, 1'b0, o);
        o = '0; o.dmem_req = 1'b1; o.dmem_we = 1'b1; o.alu_op = 3'b010; o.alu_src = 1'b1;
        push(1'b0, 1'b0, o);
        run_queue("stur pre-reset", -1, lat, eo);
        #2;
        chk("stur mem dmem_we", 32'(dmem_we), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid reset dmem_req", 32'(dmem_req), 32'd0);
        chk("mid reset dmem_we", 32'(dmem_we), 32'd0);
        chk("mid reset retired", 32'(retired), 32'd0);
        @(posedge clk);
        #1;
        chk("held reset outs", 32'(dut_out()), 32'd0);

        // Randomized instruction stream with random memory waits below the limit.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            run_instr(4'($urandom_range(0, 9)), 4'($urandom), 1'($urandom),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), lat, eo);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mc_sequencer.md
Name: mc_sequencer

Overview:
- Multi-cycle control sequencer for the LEGv8 datapath.
- Steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Handshakes with instruction and data memories that may take several cycles (ready-based).
- Takes the 4-bit OPID from the opcode classifier and drives per-cycle datapath enables. Also owns flag-write, branch resolution, a memory-wait watchdog and a retired-instruction counter.

Parameters:
- MEM_TIMEOUT, 16, max cycles a memory request may wait for ready before FAULT (must be ≥2).
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- opid  in  4  0=ADDI 1=ADDS 2=B.LT 3=B 4=BL 5=BR 6=CBZ 7=LDUR 8=STUR 9=SUBS; sampled in DECODE.
- flags  in  4  stored {N,Z,C,V} from flag register.
- alu_zero  in  1  combinational zero of current ALU result (used by CBZ in EXEC).
- imem_ready  in  1  instruction memory data valid.
- dmem_ready  in  1  data memory access complete.
- imem_req  out  1  instruction fetch request.
- ir_we  out  1  load instruction register.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write (STUR).
- mdr_we  out  1  load memory data register (LDUR).
- alu_src  out  1  0=register B, 1=immediate.
- alu_op  out  3  010 add, 011 subtract, 000 pass B.
- flag_we  out  1  update flag register.
- reg_we  out  1  register file write.
- wb_sel  out  2  00 ALU, 01 MDR, 10 PC+4.
- pc_we  out  1  update PC.
- pc_sel  out  2  00 PC+4, 01 PC+imm (imm19/imm26 per opcode), 10 register Rd.
- fault  out  1  sticky fault indicator.
- retired  out  CNT_W  retired-instruction count.

Behaviour:
- States: RST, FETCH, DECODE, EXEC, MEM, WB, FAULT.
- Reset (reset_n=0, async): state=RST, retired=0, wait counter=0. All outputs 0.
- RST -> FETCH unconditionally on the first clock after reset release.
- Output decode:
  - All outputs are decoded from state + latched opid.
  - ir_we, mdr_we and MEM-state pc_we are gated by the matching ready.
  - Unlisted outputs are 0.
- FETCH:
  - imem_req=1 every cycle.
  - On imem_ready: ir_we=1, go to DECODE.
- DECODE:
  - Latch opid.
  - opid>9 -> FAULT. Otherwise -> EXEC.
- EXEC, alu_op/alu_src by op:
  - ADDI: 010/1.
  - ADDS: 010/0.
  - SUBS: 011/0.
  - LDUR, STUR: 010/1.
  - CBZ: 000/0.
  - others: 000/0.
- EXEC, flags: flag_we=1 only for ADDS and SUBS.
- EXEC, branches:
  - B: pc_we=1, pc_sel=01.
  - BL: pc_we=1, pc_sel=01, reg_we=1, wb_sel=10.
  - BR: pc_we=1, pc_sel=10.
  - B.LT: pc_we=1, pc_sel=01 if N^V, else pc_sel=00.
  - CBZ: pc_we=1, pc_sel=01 if alu_zero, else pc_sel=00.
  - All branches -> FETCH.
- EXEC, other ops: ALU ops -> WB; LDUR/STUR -> MEM.
- MEM:
  - dmem_req=1, alu_op=010, alu_src=1 held.
  - dmem_we=1 for STUR.
  - On dmem_ready, STUR: pc_we=1, pc_sel=00 -> FETCH.
  - On dmem_ready, LDUR: mdr_we=1 -> WB.
- WB:
  - reg_we=1, pc_we=1, pc_sel=00.
  - wb_sel=01 for LDUR, else 00.
  - ALU ops hold alu_op/alu_src as in EXEC.
  - -> FETCH.
- Watchdog:
  - Counter clears on entry to FETCH/MEM and on ready.
  - Increments each FETCH/MEM cycle without ready.
  - Reaching MEM_TIMEOUT without ready -> FAULT.
  - Ready in the same cycle the count hits the limit wins: no fault.
- FAULT: fault=1, all other outputs 0, absorbing until reset_n=0.
- retired:
  - Increments by 1 on every cycle with pc_we=1.
  - Wraps at 2^CNT_W-1 -> 0.
- Latency with zero-wait memories (ready on the first request cycle):
  - B/BL/BR/B.LT/CBZ/STUR-less branches: 3 cycles.
  - ALU ops: 4 cycles.
  - STUR: 4 cycles.
  - LDUR: 5 cycles.
- Reset mid-instruction: immediate return to RST; no write enables asserted during or after.

Decomposition:
- Shared package lv8_ctrl_pkg holds:
  - opid localparams.
  - state enum.
  - alu_op, wb_sel and pc_sel encodings.
- This package is also reusable by the single-cycle decoder.
- One sub-module: mem_watchdog (counter, clear, limit compare, timeout pulse), instantiated once and shared by FETCH and MEM.

Test Plan:
- ADDS, zero-wait: reset, imem_ready=1, opid=1 -> states FETCH, DECODE, EXEC, WB. EXEC has flag_we=1, alu_op=010. WB has reg_we=1, pc_we=1. retired=1 after 5 clocks from reset release.
- LDUR with dmem_ready delayed 3 cycles: mdr_we pulses once in MEM cycle 4. WB follows with wb_sel=01. Total 8 cycles FETCH->FETCH.
- B.LT, flags=1000 (N=1, V=0): pc_sel=01 taken. Repeat with flags=1001: pc_sel=00. Neither case asserts reg_we.
- BL: a single EXEC cycle has reg_we=1, wb_sel=10, pc_we=1, pc_sel=01 together.
- Watchdog, MEM_TIMEOUT=4: imem_ready held 0 -> fault=1 after 4 FETCH cycles and stays until reset. Ready arriving on cycle 4 -> no fault.
- Illegal opid=4'hF -> FAULT after DECODE. Asserting reset_n=0 during MEM of STUR -> dmem_req/dmem_we drop immediately and retired=0.
